// File: rtl/term_uart_rx_if.sv
// Receive-side byte handshake for term_uart_rx: data/valid from the receiver, ready from the consumer.
interface term_uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/term_uart_rx.sv
// 8N1 UART receiver for the SoC terminal line, with single-byte holding register or,
// when TERM_UART_RX_FIFO_EN is defined, a FIFO_DEPTH-entry receive FIFO.
module term_uart_rx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rxd,
    term_uart_rx_if.master rx_if,
    output logic           frame_err,
    output logic           overrun,
    output logic           busy
);

    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 16 || CLKS_PER_BIT > 65535 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16) begin : g_param_check
        $error("term_uart_rx: CLKS_PER_BIT or FIFO_DEPTH out of range");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    logic [1:0]  sync_r;
    logic        rxs_s;
    state_t      state_r, next_state_s;
    logic [15:0] timer_r, next_timer_s;
    logic [2:0]  idx_r, next_idx_s;
    logic [7:0]  shreg_r, next_shreg_s;
    logic        push_s;
    logic        ferr_s;
    logic        pop_s;
    logic        full_s;
    logic        frame_err_r;
    logic        overrun_r;

    assign rxs_s = sync_r[1];

    // Two-flop synchronizer; preset high so reset looks like an idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rxd};
        end
    end

    // FSM, bit timer, bit index and shift register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            timer_r <= 16'd0;
            idx_r   <= 3'd0;
            shreg_r <= 8'h00;
        end else begin
            state_r <= next_state_s;
            timer_r <= next_timer_s;
            idx_r   <= next_idx_s;
            shreg_r <= next_shreg_s;
        end
    end

    // Next-state logic: mid-bit sampling driven by the down-counting bit timer.
    always_comb begin
        next_state_s = state_r;
        next_timer_s = timer_r;
        next_idx_s   = idx_r;
        next_shreg_s = shreg_r;
        push_s       = 1'b0;
        ferr_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rxs_s) begin
                    next_state_s = START;
                    next_timer_s = HALF_LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: begin
                if (timer_r == 16'd0) begin
                    if (rxs_s) begin
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = DATA;
                        next_timer_s = FULL_LOAD;
                        next_idx_s   = 3'd0;
                    end
                end else begin
                    next_timer_s = timer_r - 16'd1;
                end
            end
            DATA: begin
                if (timer_r == 16'd0) begin
                    next_shreg_s[idx_r] = rxs_s;
                    next_timer_s        = FULL_LOAD;
                    if (idx_r == 3'd7) begin
                        next_state_s = STOP;
                    end else begin
                        next_idx_s = idx_r + 3'd1;
                    end
                end else begin
                    next_timer_s = timer_r - 16'd1;
                end
            end
            STOP: begin
                if (timer_r == 16'd0) begin
                    if (rxs_s) begin
                        push_s       = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        ferr_s       = 1'b1;
                        next_state_s = WAIT_HI;
                    end
                end else begin
                    next_timer_s = timer_r - 16'd1;
                end
            end
            WAIT_HI: begin
                // A held-low line (break) must return high before re-arming.
                if (rxs_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_HI;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    assign pop_s = rx_if.rx_valid && rx_if.rx_ready;

`ifdef TERM_UART_RX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          accept_s;

    assign full_s   = (count_r == CNT_FULL);
    assign accept_s = push_s && (!full_s || pop_s);

    // Receive FIFO: write on accepted push, read on pop, both may happen together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= shreg_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (accept_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_s && !accept_s) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign rx_if.rx_data  = mem_r[rd_ptr_r];
    assign rx_if.rx_valid = (count_r != '0);
`else
    logic [7:0] hold_data_r;
    logic       hold_valid_r;

    assign full_s = hold_valid_r;

    // Single holding register; a pop in the same cycle frees room for the push.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data_r  <= 8'h00;
            hold_valid_r <= 1'b0;
        end else if (push_s && (!full_s || pop_s)) begin
            hold_data_r  <= shreg_r;
            hold_valid_r <= 1'b1;
        end else if (pop_s) begin
            hold_valid_r <= 1'b0;
        end else begin
            hold_valid_r <= hold_valid_r;
        end
    end

    assign rx_if.rx_data  = hold_data_r;
    assign rx_if.rx_valid = hold_valid_r;
`endif

    // Registered one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= ferr_s;
            overrun_r   <= push_s && full_s && !pop_s;
        end
    end

    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_term_uart_rx.sv
// Directed bench for term_uart_rx at 234 clk/bit; covers FIFO mode when TERM_UART_RX_FIFO_EN is defined.
module tb_term_uart_rx;
    localparam int CPB = 234;

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    logic frame_err, overrun, busy;

    term_uart_rx_if rx_if ();

    term_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_if     (rx_if),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int valid_rise_cyc = 0;
    logic prev_valid = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    int start_cyc;
    int fe0, ov0, lat;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and rx_valid rise timestamp, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
        if (rx_if.rx_valid === 1'b1 && prev_valid !== 1'b1) valid_rise_cyc <= cyc;
        prev_valid <= rx_if.rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives start, 8 data bits LSB first, then leaves rxd at the stop value after one bit time.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        start_cyc = cyc;
        wait_clk(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clk(CPB);
        end
        rxd = stop_bit;
        wait_clk(CPB);
    endtask

    task automatic pop_one();
        rx_if.rx_ready = 1'b1;
        wait_clk(1);
        rx_if.rx_ready = 1'b0;
        wait_clk(1);
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        rx_if.rx_ready = 1'b0;
        wait_clk(3);
        check("reset_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check("reset_rx_data", {24'd0, rx_if.rx_data}, 32'h00);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_clk(20);

        // Basic byte and start-edge-to-valid latency
        fe0 = fe_cnt;
        send_byte(8'h41, 1'b1);
        wait_clk(5);
        lat = valid_rise_cyc - start_cyc;
        check("byte41_latency_in_window", {31'd0, (lat >= 2220 && lat <= 2226)}, 32'd1);
        check("byte41_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        check("byte41_data", {24'd0, rx_if.rx_data}, 32'h41);
        check("byte41_no_frame_err", fe_cnt - fe0, 32'd0);
        check("byte41_busy_low", {31'd0, busy}, 32'd0);
        wait_clk(10);
        check("byte41_data_stable", {24'd0, rx_if.rx_data}, 32'h41);
        pop_one();
        check("byte41_popped", {31'd0, rx_if.rx_valid}, 32'd0);

        // Ready with nothing stored has no effect
        rx_if.rx_ready = 1'b1;
        wait_clk(5);
        rx_if.rx_ready = 1'b0;
        wait_clk(1);
        check("idle_ready_no_valid", {31'd0, rx_if.rx_valid}, 32'd0);

        // Short low glitch is rejected by the start-bit check
        fe0 = fe_cnt;
        rxd = 1'b0;
        wait_clk(50);
        rxd = 1'b1;
        wait_clk(300);
        check("glitch_no_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check("glitch_no_frame_err", fe_cnt - fe0, 32'd0);
        check("glitch_idle", {31'd0, busy}, 32'd0);

        // Bad stop bit followed by a long break gives one frame error
        fe0 = fe_cnt;
        send_byte(8'h55, 1'b0);
        wait_clk(20 * CPB);
        check("break_busy_wait_hi", {31'd0, busy}, 32'd1);
        rxd = 1'b1;
        wait_clk(2 * CPB);
        check("break_one_frame_err", fe_cnt - fe0, 32'd1);
        check("break_no_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check("break_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h0D, 1'b1);
        wait_clk(5);
        check("after_break_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        check("after_break_data", {24'd0, rx_if.rx_data}, 32'h0D);
        pop_one();

        // Overrun with consumer stalled
        ov0 = ov_cnt;
`ifdef TERM_UART_RX_FIFO_EN
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h43, 1'b1);
        send_byte(8'h0D, 1'b1);
        check("fifo_no_overrun_at_four", ov_cnt - ov0, 32'd0);
        send_byte(8'h0A, 1'b1);
        wait_clk(5);
        check("fifo_overrun_fifth", ov_cnt - ov0, 32'd1);
        check("fifo_head_41", {24'd0, rx_if.rx_data}, 32'h41);
        pop_one();
        check("fifo_head_42", {24'd0, rx_if.rx_data}, 32'h42);
        pop_one();
        check("fifo_head_43", {24'd0, rx_if.rx_data}, 32'h43);
        pop_one();
        check("fifo_head_0d", {24'd0, rx_if.rx_data}, 32'h0D);
        check("fifo_valid_before_last", {31'd0, rx_if.rx_valid}, 32'd1);
        pop_one();
        check("fifo_empty", {31'd0, rx_if.rx_valid}, 32'd0);
`else
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        wait_clk(5);
        check("hold_overrun_once", ov_cnt - ov0, 32'd1);
        check("hold_keeps_41", {24'd0, rx_if.rx_data}, 32'h41);
        check("hold_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        pop_one();
        check("hold_popped", {31'd0, rx_if.rx_valid}, 32'd0);
`endif

        // Reset during bit 4 of 0x43; the sender abandons the frame as well
        rxd = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = ((8'h43 >> i) & 8'h01) != 8'h00;
            wait_clk(CPB);
        end
        rxd = 1'b0;
        wait_clk(CPB / 2);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("midreset_rx_data_cleared", {24'd0, rx_if.rx_data}, 32'h00);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        rxd = 1'b1;
        wait_clk(2 * CPB);
        check("midreset_no_output", {31'd0, rx_if.rx_valid}, 32'd0);
        check("midreset_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h44, 1'b1);
        wait_clk(5);
        check("after_reset_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        check("after_reset_data", {24'd0, rx_if.rx_data}, 32'h44);
        pop_one();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/term_uart_rx.md
TERM_UART_RX -- requirements
Module: term_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 234, clk cycles per UART bit (27 MHz clk, 115200 bps); legal range 16..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, 2..16); used only when TERM_UART_RX_FIFO_EN is defined.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line; idle high; 8N1, LSB first (SoC terminal UART TX, gpio_out[17]).
REQ-006 SHALL have port rx_data  output  8  received byte at head of buffer.
REQ-007 SHALL have port rx_valid  output  1  rx_data holds an unread byte.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts; a byte is popped on a cycle with rx_valid && rx_ready.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because storage is full.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass rxd through a two-flop synchronizer preset to 1; all decisions use the synchronized value rxs.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HI, plus a 16-bit bit-timer and a 3-bit bit index.
REQ-014 IDLE: on rxs==0, SHALL go to START with the timer loaded to CLKS_PER_BIT/2-1.
REQ-015 START: on timer==0, SHALL sample rxs; if 1 (glitch), return to IDLE with no output; if 0, go to DATA with timer=CLKS_PER_BIT-1 and index=0.
REQ-016 DATA: on each timer==0, SHALL shift rxs into bit[index] and reload the timer; after index 7, go to STOP with timer=CLKS_PER_BIT-1.
REQ-017 STOP: on timer==0 with rxs==1, SHALL push the byte and return to IDLE in the same cycle.
REQ-018 STOP: on timer==0 with rxs==0, SHALL pulse frame_err, discard the byte, and go to WAIT_HI.
REQ-019 WAIT_HI: SHALL return to IDLE only once rxs==1, so a break condition yields exactly one frame_err.
REQ-020 A pushed byte SHALL appear on rx_data with rx_valid=1 on the cycle after the push.
REQ-021 rx_data SHALL hold stable while rx_valid=1 and rx_ready=0.
REQ-022 A push while storage is full and no pop occurs in the same cycle SHALL drop the new byte, keep stored data, and pulse overrun.
REQ-023 A push and a pop in the same cycle while full SHALL accept the new byte with no overrun.
REQ-024 rx_ready while rx_valid=0 SHALL have no effect.

Reset
REQ-025 On rst=1 at a clk edge: FSM=IDLE, synchronizer=1, timer=0, index=0, storage emptied; rx_valid=0, rx_data=8'h00, frame_err=0, overrun=0, busy=0.
REQ-026 Reset mid-frame SHALL abandon the partial byte; after reset release, reception SHALL resume on the next falling edge of rxs.

Configuration
REQ-027 With TERM_UART_RX_FIFO_EN defined, storage SHALL be a FIFO_DEPTH-entry FIFO: full at FIFO_DEPTH entries, read in arrival order, with rx_data showing the head entry.
REQ-028 Without TERM_UART_RX_FIFO_EN, storage SHALL be a single holding register, full whenever rx_valid=1.

Verification
REQ-029 CLKS_PER_BIT=234, send 0x41 at 115200 -> rx_valid=1 with rx_data=0x41 about 9.5 bit times (2223+-3 clk) after the start edge; no frame_err; busy low after the stop sample.
REQ-030 Drive rxd low for 50 clk, then high -> no rx_valid, no frame_err, FSM back in IDLE.
REQ-031 Send 0x55 with stop bit 0, then hold rxd low for 20 bit times -> exactly one frame_err pulse and no rx_valid; next byte 0x0D received correctly.
REQ-032 Macro off, rx_ready=0: send 0x41 then 0x42 -> one overrun pulse and rx_data stays 0x41; assert rx_ready one cycle -> rx_valid=0.
REQ-033 Macro on, FIFO_DEPTH=4, rx_ready=0: send A,B,C,0x0D,0x0A -> overrun on the fifth byte; popping returns 0x41,0x42,0x43,0x0D in order.
REQ-034 Assert rst for 1 clk during bit 4 of 0x43, then send 0x44 -> no output for 0x43 and rx_data=0x44 received.
